// File: rtl/mem_stage_lsu_if.sv
// Bridge bus between the M-stage load/store unit and the data-side peripherals.
// One req/ack transaction at a time; the LSU is the master.
`timescale 1ns/1ps
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: address exception check, one bus transaction per access,
// load extension, and pipeline stall until the access resolves.
`timescale 1ns/1ps
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] DM_TOP   = 32'h2FFF,
  parameter logic [31:0] TC0_BASE = 32'h7F00,
  parameter logic [31:0] TC1_BASE = 32'h7F10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       m_op,
  input  logic [31:0]      m_addr,
  input  logic             m_ov,
  input  logic [31:0]      m_wdata,
  input  logic             flush,
  mem_stage_lsu_if.master  bus,
  output logic             stall,
  output logic [31:0]      ld_data,
  output logic             exc_valid,
  output logic [4:0]       exc_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic        kill_reg, dbe_reg;
  logic [3:0]  op_reg;
  logic [1:0]  lane_reg;
  logic [31:0] ld_data_reg;
  logic        bus_req_reg, bus_we_reg;
  logic [31:0] bus_addr_reg, bus_wdata_reg;
  logic [3:0]  bus_be_reg;

  logic op_valid, is_load, is_word, is_half, is_byte;
  logic in_dm, in_tc, is_cnt, addr_err;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, ld_ext;
  logic accept, finish, timed_out;

  // Address decode for the instruction currently in M.
  always_comb begin
    op_valid = (m_op >= 4'd1) && (m_op <= 4'd8);
    is_load  = (m_op >= 4'd1) && (m_op <= 4'd5);
    is_word  = (m_op == 4'd1) || (m_op == 4'd6);
    is_half  = (m_op == 4'd2) || (m_op == 4'd3) || (m_op == 4'd7);
    is_byte  = (m_op == 4'd4) || (m_op == 4'd5) || (m_op == 4'd8);
    in_dm    = m_addr <= DM_TOP;
    in_tc    = ((m_addr >= TC0_BASE) && (m_addr <= TC0_BASE + 32'hB)) ||
               ((m_addr >= TC1_BASE) && (m_addr <= TC1_BASE + 32'hB));
    is_cnt   = (m_addr == TC0_BASE + 32'h8) || (m_addr == TC1_BASE + 32'h8);
    addr_err = m_ov
             | (is_word & (m_addr[1:0] != 2'b00))
             | (is_half & m_addr[0])
             | ~(in_dm | in_tc)
             | (in_tc & ~is_word)
             | (~is_load & is_cnt);
  end

  // Lane placement; loads use the same enables to mark the lanes they read.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = m_wdata;
    if (is_half) begin
      be_next    = m_addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{m_wdata[15:0]}};
    end else if (is_byte) begin
      be_next    = 4'b0001 << m_addr[1:0];
      wdata_next = {4{m_wdata[7:0]}};
    end
  end

  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = bus.bus_rdata[8*lane_reg +: 8];
    half_v = lane_reg[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    ld_ext = bus.bus_rdata;
    case (op_reg)
      4'd2:    ld_ext = {{16{half_v[15]}}, half_v};
      4'd3:    ld_ext = {16'h0000, half_v};
      4'd4:    ld_ext = {{24{byte_v[7]}}, byte_v};
      4'd5:    ld_ext = {24'h000000, byte_v};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    exc_valid  = 1'b0;
    exc_code   = 5'd0;
    accept     = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (op_valid && !flush) begin
          if (addr_err) begin
            exc_valid = 1'b1;
            exc_code  = is_load ? 5'd4 : 5'd5;
          end else begin
            stall      = 1'b1;
            accept     = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          finish = 1'b1;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end
        // A flushed access still completes on the bus but skips the result cycle.
        if (finish) state_next = (kill_reg || flush) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        state_next = S_IDLE;
        if (dbe_reg && !flush) begin
          exc_valid = 1'b1;
          exc_code  = 5'd7;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (reset) begin
      stall     = 1'b0;
      exc_valid = 1'b0;
      exc_code  = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      kill_reg      <= 1'b0;
      dbe_reg       <= 1'b0;
      op_reg        <= 4'd0;
      lane_reg      <= 2'd0;
      ld_data_reg   <= 32'd0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'd0;
      bus_be_reg    <= 4'd0;
      bus_wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        bus_req_reg   <= 1'b1;
        bus_we_reg    <= ~is_load;
        bus_addr_reg  <= {m_addr[31:2], 2'b00};
        bus_be_reg    <= be_next;
        bus_wdata_reg <= wdata_next;
        op_reg        <= m_op;
        lane_reg      <= m_addr[1:0];
        cnt_reg       <= '0;
        kill_reg      <= 1'b0;
        dbe_reg       <= 1'b0;
      end
      if (state_reg == S_WAIT) begin
        if (flush) kill_reg <= 1'b1;
        if (finish) begin
          bus_req_reg <= 1'b0;
          dbe_reg     <= timed_out & ~(kill_reg | flush);
          if (bus.bus_ack && !(kill_reg || flush) && (op_reg <= 4'd5))
            ld_data_reg <= ld_ext;
        end else if (cnt_reg != {CW{1'b1}}) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (state_reg == S_HOLD) dbe_reg <= 1'b0;
    end
  end

  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_we    = bus_we_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_be    = bus_be_reg;
  assign bus.bus_wdata = bus_wdata_reg;
  assign ld_data       = ld_data_reg;

endmodule
